// File: rtl/qdma_mc_fifo_lut_if.sv
// Beat stream bundle used on both sides of the multi-channel FIFO.
// master drives the beat and its valid; slave returns ready.
interface qdma_mc_fifo_lut_if #(
  parameter int DATA_BITS = 128,
  parameter int SB_BITS   = 5,
  parameter int CH_BITS   = 2
);
  logic [DATA_BITS-1:0] data;
  logic [SB_BITS-1:0]   sb;
  logic                 last;
  logic [CH_BITS-1:0]   ch;
  logic                 vld;
  logic                 rdy;

  modport master (output data, output sb, output last, output ch, output vld, input rdy);
  modport slave  (input data, input sb, input last, input ch, input vld, output rdy);
endinterface

// File: rtl/qdma_mc_fifo_lut.sv
// qdma_mc_fifo_lut: NUM_CH independent queues sharing one distributed RAM,
// per-channel upstream credit pools and a packet-atomic round-robin output.
// Optional store-and-forward mode: define QDMA_MC_FIFO_PKT_MODE_EN.
//
// Arbiter states:
//   state    | meaning
//   ARB_FREE | no packet in flight, round-robin from channel after last winner
//   ARB_LOCK | mid-packet on lock_ch, only lock_ch may load (waits if empty)
module qdma_mc_fifo_lut #(
  parameter int DATA_BITS  = 128,
  parameter int SB_BITS    = 5,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CH_BITS    = $clog2(NUM_CH),
  parameter int CNT_BITS   = $clog2(FIFO_DEPTH + 1),
  parameter int EN_CRDT    = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  qdma_mc_fifo_lut_if.slave          in_s,
  qdma_mc_fifo_lut_if.master         out_m,
  input  logic                       crdt_req,
  input  logic [CH_BITS-1:0]         crdt_req_ch,
  input  logic [CNT_BITS-1:0]        crdt_req_cnt,
  output logic                       crdt_gnt,
  output logic [NUM_CH*CNT_BITS-1:0] ch_cnt,
  output logic [NUM_CH*CNT_BITS-1:0] ch_crdt,
  output logic                       ovrflow
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int ENT_BITS = DATA_BITS + SB_BITS + 1;
  localparam int CW       = CNT_BITS + 1;
  localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(FIFO_DEPTH);

  typedef enum logic {ARB_FREE, ARB_LOCK} arb_e;

  // entry layout {data, sb, last}
  logic [ENT_BITS-1:0] mem [NUM_CH*FIFO_DEPTH];

  logic [PTR_BITS-1:0] wptr [NUM_CH];
  logic [PTR_BITS-1:0] rptr [NUM_CH];
  logic [CNT_BITS-1:0] cnt  [NUM_CH];
  logic [CNT_BITS-1:0] crdt [NUM_CH];
  logic [CNT_BITS-1:0] crdt_nxt [NUM_CH];
  logic [CW-1:0]       crdt_acc;
  logic [CW-1:0]       crdt_sum;

  arb_e                state, state_nxt;
  logic [CH_BITS-1:0]  lock_ch, lock_ch_nxt;
  logic [CH_BITS-1:0]  rr, rr_nxt;
  logic [CH_BITS-1:0]  cand;
  logic [NUM_CH-1:0]   elig;
  logic                win_vld;
  logic [CH_BITS-1:0]  win_ch;
  logic                load;
  logic [ENT_BITS-1:0] rd_ent;
  logic                in_rdy_c;
  logic                push;
  logic                ret;

  logic [DATA_BITS-1:0] out_data_q;
  logic [SB_BITS-1:0]   out_sb_q;
  logic                 out_last_q;
  logic [CH_BITS-1:0]   out_ch_q;
  logic                 out_vld_q;

  // Input acceptance: no bypass, so fullness is judged on current occupancy only
  always_comb begin
    in_rdy_c = (cnt[in_s.ch] < DEPTH_C);
`ifdef QDMA_MC_FIFO_PKT_MODE_EN
    // keep the last slot for an end-of-packet beat so a full queue holds a whole packet
    if (!in_s.last && (cnt[in_s.ch] >= DEPTH_C - CNT_BITS'(1)))
      in_rdy_c = 1'b0;
`endif
  end

  assign in_s.rdy = in_rdy_c;
  assign push     = in_s.vld & in_rdy_c;

`ifdef QDMA_MC_FIFO_PKT_MODE_EN
  logic [CNT_BITS-1:0] pkt_cnt [NUM_CH];

  // Complete packets per channel: count on last-beat push, release on last-beat pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) pkt_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ((push && in_s.last && in_s.ch == CH_BITS'(c)) &&
            !(load && rd_ent[0] && win_ch == CH_BITS'(c)))
          pkt_cnt[c] <= pkt_cnt[c] + CNT_BITS'(1);
        else if (!(push && in_s.last && in_s.ch == CH_BITS'(c)) &&
                 (load && rd_ent[0] && win_ch == CH_BITS'(c)))
          pkt_cnt[c] <= pkt_cnt[c] - CNT_BITS'(1);
      end
    end
  end

  // Store-and-forward eligibility: a complete packet is waiting
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) elig[c] = (pkt_cnt[c] != '0);
  end
`else
  // Cut-through eligibility: any beat waiting
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) elig[c] = (cnt[c] != '0);
  end
`endif

  // Arbiter state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ARB_FREE;
      lock_ch <= '0;
      rr      <= '0;
    end else begin
      state   <= state_nxt;
      lock_ch <= lock_ch_nxt;
      rr      <= rr_nxt;
    end
  end

  // Arbiter outputs: winner selection and output-register load strobe
  always_comb begin
    win_vld = 1'b0;
    win_ch  = lock_ch;
    cand    = '0;
    if (state == ARB_LOCK) begin
      // the rest of the packet is already buffered in pkt mode, so cnt>0 suffices
      win_vld = (cnt[lock_ch] != '0);
    end else begin
      // scan from the highest offset down so the nearest eligible channel wins
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        cand = rr + CH_BITS'(i);
        if (elig[cand]) begin
          win_vld = 1'b1;
          win_ch  = cand;
        end
      end
    end
    load   = (!out_vld_q | out_m.rdy) & win_vld;
    rd_ent = mem[{win_ch, rptr[win_ch]}];
  end

  // Arbiter next state: last=0 locks onto the channel, last=1 frees and advances RR
  always_comb begin
    state_nxt   = state;
    lock_ch_nxt = lock_ch;
    rr_nxt      = rr;
    if (load) begin
      if (rd_ent[0]) begin
        state_nxt = ARB_FREE;
        rr_nxt    = win_ch + CH_BITS'(1);
      end else begin
        state_nxt   = ARB_LOCK;
        lock_ch_nxt = win_ch;
      end
    end
  end

  // Shared RAM write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (push) mem[{in_s.ch, wptr[in_s.ch]}] <= {in_s.data, in_s.sb, in_s.last};
  end

  // Per-channel pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr[c] <= '0;
        rptr[c] <= '0;
        cnt[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (push && in_s.ch == CH_BITS'(c)) wptr[c] <= wptr[c] + PTR_BITS'(1);
        if (load && win_ch == CH_BITS'(c)) rptr[c] <= rptr[c] + PTR_BITS'(1);
        if ((push && in_s.ch == CH_BITS'(c)) && !(load && win_ch == CH_BITS'(c)))
          cnt[c] <= cnt[c] + CNT_BITS'(1);
        else if (!(push && in_s.ch == CH_BITS'(c)) && (load && win_ch == CH_BITS'(c)))
          cnt[c] <= cnt[c] - CNT_BITS'(1);
      end
    end
  end

  // Output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_sb_q   <= '0;
      out_last_q <= 1'b0;
      out_ch_q   <= '0;
    end else if (load) begin
      out_vld_q                            <= 1'b1;
      {out_data_q, out_sb_q, out_last_q}   <= rd_ent;
      out_ch_q                             <= win_ch;
    end else if (out_m.rdy) begin
      out_vld_q <= 1'b0;
    end
  end

  assign out_m.data = out_data_q;
  assign out_m.sb   = out_sb_q;
  assign out_m.last = out_last_q;
  assign out_m.ch   = out_ch_q;
  assign out_m.vld  = out_vld_q;

  // Credit grant: a pop on the requested channel this cycle counts as returned
  always_comb begin
    ret      = load && (win_ch == crdt_req_ch);
    crdt_sum = {1'b0, crdt[crdt_req_ch]} + CW'(ret);
    crdt_gnt = (EN_CRDT != 0) && crdt_req && (crdt_sum >= {1'b0, crdt_req_cnt});
  end

  // Next credit balance per channel, capped at FIFO_DEPTH
  always_comb begin
    crdt_acc = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      crdt_acc = {1'b0, crdt[c]};
      if (load && win_ch == CH_BITS'(c)) crdt_acc = crdt_acc + CW'(1);
      if (crdt_gnt && crdt_req_ch == CH_BITS'(c)) crdt_acc = crdt_acc - {1'b0, crdt_req_cnt};
      if (crdt_acc > {1'b0, DEPTH_C}) crdt_acc = {1'b0, DEPTH_C};
      crdt_nxt[c] = crdt_acc[CNT_BITS-1:0];
    end
  end

  // Credit pools and sticky overflow flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) crdt[c] <= (EN_CRDT != 0) ? DEPTH_C : '0;
      ovrflow <= 1'b0;
    end else if (EN_CRDT != 0) begin
      for (int c = 0; c < NUM_CH; c++) crdt[c] <= crdt_nxt[c];
      if (in_s.vld && !in_rdy_c) ovrflow <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
    assign ch_cnt[g*CNT_BITS +: CNT_BITS]  = cnt[g];
    assign ch_crdt[g*CNT_BITS +: CNT_BITS] = crdt[g];
  end

endmodule
